// File: rtl/poly_loader.sv
// poly_loader: sequencing master for the quadratic evaluator's serial Go/DataIn
// load protocol. It accepts one (A, B, C, X) request and presents each operand
// on DataIn with a Go high-then-low pulse. It then waits out the evaluator's
// compute time, captures DataResult and returns it over a valid/ready handshake.
// Optional feature macro: POLY_LOADER_CHECK_EN. When defined, a local golden
// model flags any mismatch on res_err.
module poly_loader #(
  parameter int GO_HIGH_CYCLES = 2,
  parameter int GO_LOW_CYCLES  = 1,
  parameter int RESULT_DELAY   = 6
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_c,
  input  logic [7:0] req_x,
  output logic       Go,
  output logic [7:0] DataIn,
  input  logic [7:0] DataResult,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE_HI,
    DRIVE_LO,
    COMPUTE,
    RESULT
  } state_t;

  // Terminal values of the shared cycle counter in each timed state.
  localparam logic [7:0] HI_LAST   = 8'(GO_HIGH_CYCLES - 1);
  localparam logic [7:0] LO_LAST   = 8'(GO_LOW_CYCLES - 1);
  localparam logic [7:0] COMP_LAST = 8'(RESULT_DELAY);

  state_t     state, state_next;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [7:0] op_a, op_b, op_c, op_x;
  logic [7:0] cur_op;
  logic       hi_done, lo_done, comp_done;
  logic       accept;
  logic [7:0] res_data_q;

  assign hi_done   = (cnt == HI_LAST);
  assign lo_done   = (cnt == LO_LAST);
  assign comp_done = (cnt == COMP_LAST);
  assign accept    = (state == IDLE) && req_valid;

  // Operand currently being presented to the evaluator.
  always_comb begin
    case (idx)
      2'd0:    cur_op = op_a;
      2'd1:    cur_op = op_b;
      2'd2:    cur_op = op_c;
      default: cur_op = op_x;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (req_valid) state_next = DRIVE_HI;
      DRIVE_HI: if (hi_done)   state_next = (idx == 2'd3) ? COMPUTE : DRIVE_LO;
      DRIVE_LO: if (lo_done)   state_next = DRIVE_HI;
      COMPUTE:  if (comp_done) state_next = RESULT;
      RESULT:   if (res_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready = 1'b0;
    Go        = 1'b0;
    DataIn    = 8'd0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      DRIVE_HI: begin
        Go     = 1'b1;
        DataIn = cur_op;
      end
      DRIVE_LO: DataIn = cur_op;
      COMPUTE:  DataIn = op_x;
      RESULT: begin
        DataIn    = op_x;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand index and the cycle counter shared by all timed states.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx <= 2'd0;
      cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          idx <= 2'd0;
          cnt <= 8'd0;
        end
        DRIVE_HI: cnt <= hi_done ? 8'd0 : cnt + 8'd1;
        DRIVE_LO: begin
          if (lo_done) begin
            cnt <= 8'd0;
            idx <= idx + 2'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COMPUTE:  cnt <= comp_done ? 8'd0 : cnt + 8'd1;
        default:  cnt <= 8'd0;
      endcase
    end
  end

  // Operand capture on accept; later req_* changes are ignored.
  // NOTE: the operand holding registers carry no reset; they are always
  // written on accept before anything reads them.
  always_ff @(posedge Clock) begin
    if (!Reset && accept) begin
      op_a <= req_a;
      op_b <= req_b;
      op_c <= req_c;
      op_x <= req_x;
    end
  end

  // Result capture on the edge that ends the last COMPUTE cycle.
  always_ff @(posedge Clock) begin
    if (Reset)                               res_data_q <= 8'd0;
    else if ((state == COMPUTE) && comp_done) res_data_q <= DataResult;
  end

  assign res_data = res_data_q;

`ifdef POLY_LOADER_CHECK_EN
  logic [7:0] golden_calc;
  logic [7:0] golden_q;
  logic       res_err_q;

  // Modulo-256 golden value; 8-bit operands in an 8-bit context truncate
  // exactly like the evaluator's datapath.
  always_comb begin
    golden_calc = op_a * op_x * op_x + op_b * op_x + op_c;
  end

  // Golden value registered on entry to COMPUTE.
  always_ff @(posedge Clock) begin
    if (!Reset && (state == DRIVE_HI) && hi_done && (idx == 2'd3))
      golden_q <= golden_calc;
  end

  // Mismatch flag captured together with the result.
  always_ff @(posedge Clock) begin
    if (Reset)                               res_err_q <= 1'b0;
    else if ((state == COMPUTE) && comp_done) res_err_q <= (DataResult != golden_q);
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: doc/poly_loader.md
# poly_loader

Sequencing master for the quadratic evaluator's serial `Go`/`DataIn` load protocol. It accepts one parallel request (A, B, C, X) over a valid/ready handshake and presents each operand on `DataIn` with a `Go` high-then-low pulse, in order A, B, C, X. It then waits out the evaluator's five-cycle compute, captures `DataResult`, and returns it over a valid/ready result handshake. It sits between a host/testbench and the evaluator, driving the evaluator's `Go` and `DataIn` and reading its `DataResult`.

## Interface
- Parameter `GO_HIGH_CYCLES`, default 2: cycles `Go` is held high per operand; legal minimum 1.
- Parameter `GO_LOW_CYCLES`, default 1: cycles `Go` is held low after operands A, B and C; legal minimum 1.
- Parameter `RESULT_DELAY`, default 6: cycle index, counted from the first `Go`-low cycle after X, at which `DataResult` is sampled; legal minimum 6.
- `Clock` input, 1 bit: single clock, rising edge.
- `Reset` input, 1 bit: synchronous, active-high. The system ties the evaluator's `Resetn` to `~Reset`.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: high only in IDLE.
- `req_a`, `req_b`, `req_c`, `req_x` inputs, 8 bits each: operands, sampled on accept.
- `Go` output, 1 bit: drives the evaluator's `Go`.
- `DataIn` output, 8 bits: drives the evaluator's `DataIn`.
- `DataResult` input, 8 bits: the evaluator's result register.
- `res_valid` output, 1 bit: result available.
- `res_ready` input, 1 bit: consumer accepts the result.
- `res_data` output, 8 bits: captured result.
- `res_err` output, 1 bit: self-check mismatch flag (see Configuration).
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- States: IDLE, DRIVE_HI, DRIVE_LO, COMPUTE, RESULT.
- Registers: 2-bit operand index `idx` (0=A, 1=B, 2=C, 3=X) and one 8-bit cycle counter `cnt` shared by all timed states.
- IDLE:
  - `req_ready`=1.
  - If `req_valid`, latch all four operands, set `idx`=0 and `cnt`=0, and go to DRIVE_HI.
- DRIVE_HI:
  - `Go`=1 and `DataIn`=operand[idx].
  - After `GO_HIGH_CYCLES` cycles: if `idx`<3 go to DRIVE_LO; if `idx`=3 go to COMPUTE.
- DRIVE_LO:
  - `Go`=0 and `DataIn` still holds operand[idx].
  - After `GO_LOW_CYCLES` cycles, increment `idx` and go to DRIVE_HI.
- COMPUTE:
  - `Go`=0 and `DataIn`=X.
  - Lasts `RESULT_DELAY`+1 cycles.
  - On the edge ending the last cycle, `res_data`<=`DataResult`; then go to RESULT.
- RESULT:
  - `res_valid`=1; `res_data` and `res_err` are held stable.
  - On `res_valid`&&`res_ready`, go to IDLE.
  - No new request is accepted until the result is consumed.
- `Go` is 0 in IDLE, COMPUTE and RESULT. `DataIn` is 0 in IDLE.
- `req_*` changes after acceptance have no effect.
- Arithmetic (self-check only): 8-bit modulo-256 result, computed as ((A·X mod 256)·X + B·X + C) mod 256, matching the evaluator's 8-bit truncation.

## Timing
- Reset values: state IDLE, `Go`=0, `DataIn`=0, `req_ready`=1 (combinational from IDLE), `res_valid`=0, `res_data`=0, `res_err`=0, `busy`=0, `idx`=0, `cnt`=0.
- Latency from the accept edge to the first `res_valid` cycle is 4·`GO_HIGH_CYCLES` + 3·`GO_LOW_CYCLES` + `RESULT_DELAY` + 1; with defaults this is 18 cycles.
- Per-operand `Go` pulse: `Go` is exactly `GO_HIGH_CYCLES` wide and `DataIn` is stable for the whole pulse.
- The evaluator enters its first compute cycle one cycle after the first COMPUTE cycle. Its result register updates at the end of COMPUTE cycle 5 (0-based), so sampling at index 6 is the earliest correct point.
- Reset asserted in any state returns the block to IDLE on the next edge with `Go`=0. The evaluator resets on the same edge, so no partial load survives.
- `req_valid` is ignored while `busy`. `res_ready` is ignored unless `res_valid`.
- `Reset` has priority over all handshakes in the same cycle.

## Configuration
- Macro `POLY_LOADER_CHECK_EN`.
- Defined:
  - The latched operands feed a local golden computation (the modulo-256 formula above), registered on entry to COMPUTE.
  - On capture, `res_err`<=(`DataResult` != golden). `res_err` is valid while `res_valid`.
- Undefined: no golden logic is compiled in and `res_err` is tied to 0.

## Test plan
- A=1, B=2, C=3, X=4, `res_ready`=1 with defaults -> exactly four `Go` pulses, each 2 cycles high, with `DataIn` 1, 2, 3, 4; `res_valid` asserts 18 cycles after accept; `res_data`=27; `res_err`=0.
- A=1, B=1, C=1, X=16 -> `res_data`=17 (wrap-around of 273).
- A=2, B=3, C=5, X=10, with `res_ready` held low for 10 cycles -> `res_valid` and `res_data`=235 held stable; `req_ready`=0 throughout; accepted on the cycle `res_ready` rises; IDLE on the next cycle.
- `req_valid` pulsed during DRIVE_HI of a request -> ignored; the result matches the first request only.
- `Reset` asserted during DRIVE_HI for operand C -> next cycle `Go`=0, `busy`=0, `res_valid`=0. A fresh request A=1, B=2, C=3, X=4 then returns 27.
- With `POLY_LOADER_CHECK_EN`, the evaluator model forced to return 0x00 for A=1, B=2, C=3, X=4 -> `res_err`=1 with `res_valid`.
